// File: rtl/rv32_pkg.sv
// Shared RV32 fetch-stage types and constants.
// Imported by pc_next_calc and fetch_unit.
package rv32_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        TRAP  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC: sequential PC+4 or branch target InstrPC+ImmExt (modulo 2^XLEN).
// Flags a target whose low two bits are nonzero.
module pc_next_calc
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] InstrPC,
    input  logic [XLEN-1:0] ImmExt,
    input  logic            BranchTaken,
    output logic [XLEN-1:0] NextPC,
    output logic            Misaligned
);

    assign NextPC     = BranchTaken ? (InstrPC + ImmExt) : (InstrPC + XLEN'(4));
    assign Misaligned = |NextPC[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem valid/ready request, hold-until-accept output.
// Optional FETCH_MISALIGN_TRAP_EN adds TrapMisaligned and a sticky TRAP state.
module fetch_unit
    import rv32_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemValid,
    input  logic [XLEN-1:0] ImemRdata,
    output logic [XLEN-1:0] Instruction,
    output logic [XLEN-1:0] InstrPC,
    output logic            InstrValid,
    input  logic            DecodeReady,
    input  logic            BranchTaken,
    input  logic [XLEN-1:0] ImmExt
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            TrapMisaligned
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic            started_q;
    logic [XLEN-1:0] next_pc;
    logic            misaligned;

    pc_next_calc #(.XLEN(XLEN)) u_pc_next_calc (
        .InstrPC     (ipc_q),
        .ImmExt      (ImmExt),
        .BranchTaken (BranchTaken),
        .NextPC      (next_pc),
        .Misaligned  (misaligned)
    );

    // Keeps ImemReq low while in reset and for the release cycle, so the first
    // request appears one clock after rst_n deasserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q <= 1'b0;
        end else begin
            started_q <= 1'b1;
        end
    end

    // NOTE: non-blocking assignments for every register so all state updates
    // see the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            ipc_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
        end
    end

    // NOTE: every variable gets a hold default first, so no path through the
    // case can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        case (state_q)
            FETCH: begin
                if (ImemReq && ImemValid) begin
                    instr_d = ImemRdata;
                    ipc_d   = pc_q;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (DecodeReady) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    pc_d    = next_pc;
                    state_d = misaligned ? TRAP : FETCH;
`else
                    pc_d    = misaligned ? {next_pc[XLEN-1:2], 2'b00} : next_pc;
                    state_d = FETCH;
`endif
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            TRAP: begin
                state_d = TRAP;
            end
`endif
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign ImemReq     = started_q && (state_q == FETCH);
    assign ImemAddr    = pc_q;
    assign Instruction = instr_q;
    assign InstrPC     = ipc_q;
    assign InstrValid  = (state_q == HOLD);
`ifdef FETCH_MISALIGN_TRAP_EN
    assign TrapMisaligned = (state_q == TRAP);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed steps plus randomized transactions
// against a PC-level reference model. Honours FETCH_MISALIGN_TRAP_EN.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemValid;
    logic [31:0] ImemRdata;
    logic [31:0] Instruction;
    logic [31:0] InstrPC;
    logic        InstrValid;
    logic        DecodeReady;
    logic        BranchTaken;
    logic [31:0] ImmExt;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        TrapMisaligned;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] pc_m;
    logic [31:0] ipc_m;
    logic [31:0] instr_m;
    logic        trapped_m;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ImemReq     (ImemReq),
        .ImemAddr    (ImemAddr),
        .ImemValid   (ImemValid),
        .ImemRdata   (ImemRdata),
        .Instruction (Instruction),
        .InstrPC     (InstrPC),
        .InstrValid  (InstrValid),
        .DecodeReady (DecodeReady),
        .BranchTaken (BranchTaken),
        .ImmExt      (ImmExt)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .TrapMisaligned (TrapMisaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural next-PC rule, independent of how the DUT builds it.
    function automatic logic [31:0] model_next(input logic [31:0] ipc, input logic taken,
                                               input logic [31:0] imm);
        logic [31:0] t;
        t = taken ? ipc + imm : ipc + 32'd4;
`ifndef FETCH_MISALIGN_TRAP_EN
        t = t & 32'hFFFF_FFFC;
`endif
        return t;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},   32'(ImemReq),    32'd0);
        check({tag, "_addr"},  ImemAddr,        32'd0);
        check({tag, "_instr"}, Instruction,     NOP);
        check({tag, "_ipc"},   InstrPC,         32'd0);
        check({tag, "_ivld"},  32'(InstrValid), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check({tag, "_trap"},  32'(TrapMisaligned), 32'd0);
`endif
    endtask

    // Called at a negedge; asserts reset asynchronously and ends at the negedge
    // where the first request should be visible.
    task automatic apply_reset(input string tag);
        rst_n       = 1'b0;
        ImemValid   = 1'b0;
        DecodeReady = 1'b0;
        BranchTaken = 1'b0;
        #1;
        check_reset_values(tag);
        pc_m      = 32'd0;
        ipc_m     = 32'd0;
        instr_m   = NOP;
        trapped_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check({tag, "_req_before_clk"}, 32'(ImemReq), 32'd0);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Request held for wait_n idle cycles, then data returned.
    task automatic do_fetch(input int wait_n, input logic [31:0] data);
        logic [31:0] junk;
        for (int i = 0; i <= wait_n; i++) begin
            check("fetch_req",  32'(ImemReq), 32'd1);
            check("fetch_addr", ImemAddr,     pc_m);
            DecodeReady = 1'($urandom);
            BranchTaken = 1'($urandom);
            junk        = $urandom;
            ImmExt      = junk;
            if (i == wait_n) begin
                ImemValid = 1'b1;
                ImemRdata = data;
            end
            @(posedge clk);
            @(negedge clk);
        end
        ImemValid   = 1'b0;
        DecodeReady = 1'b0;
        ipc_m       = pc_m;
        instr_m     = data;
        check("cap_ivld",  32'(InstrValid), 32'd1);
        check("cap_ipc",   InstrPC,         ipc_m);
        check("cap_instr", Instruction,     instr_m);
        check("cap_req",   32'(ImemReq),    32'd0);
    endtask

    // Stall stall_n cycles with noise on ignored inputs, then accept.
    task automatic do_hold(input int stall_n, input logic taken, input logic [31:0] imm);
        logic [31:0] tgt;
        for (int i = 0; i < stall_n; i++) begin
            DecodeReady = 1'b0;
            BranchTaken = 1'($urandom);
            ImmExt      = $urandom;
            ImemValid   = 1'($urandom);
            ImemRdata   = $urandom;
            @(posedge clk);
            @(negedge clk);
            check("stall_ivld",  32'(InstrValid), 32'd1);
            check("stall_instr", Instruction,     instr_m);
            check("stall_ipc",   InstrPC,         ipc_m);
            check("stall_req",   32'(ImemReq),    32'd0);
        end
        ImemValid   = 1'b0;
        DecodeReady = 1'b1;
        BranchTaken = taken;
        ImmExt      = imm;
        @(posedge clk);
        @(negedge clk);
        DecodeReady = 1'b0;
        BranchTaken = 1'b0;
        tgt  = model_next(ipc_m, taken, imm);
        pc_m = tgt;
`ifdef FETCH_MISALIGN_TRAP_EN
        trapped_m = (tgt[1:0] != 2'b00);
        check("acc_trap", 32'(TrapMisaligned), 32'(trapped_m));
`endif
        check("acc_ivld", 32'(InstrValid), 32'd0);
        check("acc_req",  32'(ImemReq),    trapped_m ? 32'd0 : 32'd1);
        check("acc_addr", ImemAddr,        pc_m);
    endtask

    initial begin
        logic [31:0] imm;
        rst_n       = 1'b0;
        ImemValid   = 1'b0;
        ImemRdata   = 32'd0;
        DecodeReady = 1'b0;
        BranchTaken = 1'b0;
        ImmExt      = 32'd0;
        trapped_m   = 1'b0;

        @(negedge clk);
        apply_reset("reset");

        // First fetch: memory answers one cycle after the request.
        do_fetch(1, 32'h00A0_0093);
        do_hold(0, 1'b0, 32'h0);                 // -> 0x4
        check("seq_pc4", pc_m, 32'h4);

        do_fetch(0, 32'h1111_1111);
        do_hold(1, 1'b1, 32'h0000_00FC);         // 0x4 + 0xFC -> 0x100
        do_fetch(0, 32'h2222_2222);
        do_hold(0, 1'b1, 32'hFFFF_FFF0);         // 0x100 - 16 -> 0xF0
        check("neg_imm", pc_m, 32'hF0);

        // Long decode stall with spurious ImemValid.
        do_fetch(2, 32'h3333_3333);
        do_hold(5, 1'b0, 32'h0);

        // Slow memory, reset while waiting.
        for (int i = 0; i < 3; i++) begin
            check("wait_req",  32'(ImemReq), 32'd1);
            check("wait_addr", ImemAddr,     pc_m);
            @(posedge clk);
            @(negedge clk);
        end
        apply_reset("midreset");

        // Wrap at the top of the address space.
        do_fetch(0, 32'h4444_4444);
        do_hold(0, 1'b1, 32'hFFFF_FFFC);         // 0 - 4 -> 0xFFFFFFFC
        do_fetch(1, 32'h5555_5555);
        do_hold(0, 1'b0, 32'h0);                 // wraps to 0
        check("wrap", pc_m, 32'h0);

        // Misaligned taken target 0x102.
        do_fetch(0, 32'h6666_6666);
        do_hold(0, 1'b1, 32'h0000_0100);
        do_fetch(0, 32'h7777_7777);
        do_hold(0, 1'b1, 32'h0000_0002);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("trap_addr", ImemAddr, 32'h102);
        for (int i = 0; i < 4; i++) begin
            ImemValid   = 1'($urandom);
            DecodeReady = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("trap_sticky", 32'(TrapMisaligned), 32'd1);
            check("trap_req",    32'(ImemReq),        32'd0);
            check("trap_ivld",   32'(InstrValid),     32'd0);
        end
        apply_reset("trapreset");
`else
        check("align_addr", ImemAddr, 32'h100);
`endif

        // Randomized transactions.
        for (int n = 0; n < 30; n++) begin
            imm = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            imm = imm & 32'hFFFF_FFFC;
`endif
            do_fetch($urandom_range(0, 3), $urandom);
            do_hold($urandom_range(0, 3), 1'($urandom), imm);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
